// File: rtl/axil_regfile_pkg.sv
// Shared constants for the AXI4-Lite register file: response codes and
// the data value returned on a rejected read.
package axil_regfile_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] RD_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a vector of independent asynchronous bits.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
module bit_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  // Shift the asynchronous input through STAGES flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite slave register file: N_CTRL read/write control registers
// followed by N_STAT read-only status registers with optional sticky
// (write-1-to-clear) bits. Unmapped word indices answer SLVERR.
module s_axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int N_CTRL      = 4,
  parameter int N_STAT      = 4,
  parameter logic [N_CTRL*DATA_WIDTH-1:0] CTRL_RESET  = '0,
  parameter logic [N_STAT*DATA_WIDTH-1:0] STICKY_MASK = '0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         axi_clock,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH+1:0]        s_axil_awaddr,
  input  logic [2:0]                   s_axil_awprot,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [DATA_WIDTH-1:0]        s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [ADDR_WIDTH+1:0]        s_axil_araddr,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [DATA_WIDTH-1:0]        s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [N_CTRL*DATA_WIDTH-1:0] ctrl_regs,
  output logic [N_CTRL-1:0]            ctrl_wr_pulse,
  input  logic [N_STAT*DATA_WIDTH-1:0] stat_in
);

  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam int          STAT_W = N_STAT * DATA_WIDTH;
  localparam logic [31:0] N_REGS = 32'(N_CTRL + N_STAT);

  logic                    r_aw_full;
  logic [ADDR_WIDTH-1:0]   r_aw_idx;
  logic                    r_w_full;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic [N_CTRL*DATA_WIDTH-1:0] r_ctrl;
  logic [N_CTRL-1:0]       r_pulse;
  logic [STAT_W-1:0]       r_sticky;

  logic [STAT_W-1:0]       w_sync;
  logic [STAT_W-1:0]       w_clr;
  logic                    w_commit;
  logic                    w_wr_err;
  logic                    w_ar_hs;
  logic [ADDR_WIDTH-1:0]   w_ar_idx;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    w_rd_err;
  logic                    w_unused;

  // Protection bits and sub-word address bits carry no meaning here
  assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  bit_sync #(
    .WIDTH  (STAT_W),
    .STAGES (SYNC_STAGES)
  ) u_stat_sync (
    .i_clk   (axi_clock),
    .i_rst_n (rst_n),
    .i_d     (stat_in),
    .o_q     (w_sync)
  );

  // A write commits once both halves are held and the B slot is free
  assign w_commit = r_aw_full & r_w_full & (~r_bvalid | s_axil_bready);
  assign w_wr_err = 32'(r_aw_idx) >= N_REGS;
  assign w_ar_hs  = s_axil_arvalid & ~r_rvalid;
  assign w_ar_idx = s_axil_araddr[ADDR_WIDTH+1:2];

  // Capture AW and W independently; respond on B after the commit
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (s_axil_awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axil_awaddr[ADDR_WIDTH+1:2];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (s_axil_wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Byte-lane update of control registers plus the per-register write strobe
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= CTRL_RESET;
      r_pulse <= '0;
    end else begin
      for (int k = 0; k < N_CTRL; k++) begin
        r_pulse[k] <= w_commit && (r_aw_idx == ADDR_WIDTH'(k)) && (|r_wstrb);
        for (int b = 0; b < STRB_W; b++) begin
          if (w_commit && (r_aw_idx == ADDR_WIDTH'(k)) && r_wstrb[b])
            r_ctrl[k*DATA_WIDTH + b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // W1C clear mask for status registers, restricted to strobed byte lanes
  always_comb begin
    w_clr = '0;
    for (int s = 0; s < N_STAT; s++) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_commit && (r_aw_idx == ADDR_WIDTH'(N_CTRL + s)) && r_wstrb[b])
          w_clr[s*DATA_WIDTH + b*8 +: 8] = r_wdata[b*8 +: 8];
      end
    end
  end

  // Sticky bits: a synchronised 1 sets, W1C clears, set wins on a tie
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) r_sticky <= '0;
    else        r_sticky <= ((r_sticky & ~w_clr) | w_sync) & STICKY_MASK;
  end

  // Read mux over control and status words; unmapped indices flag an error
  always_comb begin
    w_rd_data = DATA_WIDTH'(RD_ERR_DATA);
    w_rd_err  = 1'b1;
    for (int k = 0; k < N_CTRL; k++) begin
      if (w_ar_idx == ADDR_WIDTH'(k)) begin
        w_rd_data = r_ctrl[k*DATA_WIDTH +: DATA_WIDTH];
        w_rd_err  = 1'b0;
      end
    end
    for (int s = 0; s < N_STAT; s++) begin
      if (w_ar_idx == ADDR_WIDTH'(N_CTRL + s)) begin
        w_rd_data = (r_sticky[s*DATA_WIDTH +: DATA_WIDTH] &  STICKY_MASK[s*DATA_WIDTH +: DATA_WIDTH]) |
                    (w_sync[s*DATA_WIDTH +: DATA_WIDTH]   & ~STICKY_MASK[s*DATA_WIDTH +: DATA_WIDTH]);
        w_rd_err  = 1'b0;
      end
    end
  end

  // Register the read response and hold it until the master takes it
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axil_awready = ~r_aw_full;
  assign s_axil_wready  = ~r_w_full;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = ~r_rvalid;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign ctrl_regs      = r_ctrl;
  assign ctrl_wr_pulse  = r_pulse;

endmodule

// File: tb/tb_s_axil_regfile.sv
// Directed bench for s_axil_regfile: 4 control + 4 status registers,
// control reg0 resets to 1, status word 0 low byte is sticky.
module tb_s_axil_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, arvalid, arready, rvalid, rready;
  logic [127:0] ctrl_regs;
  logic [3:0]   ctrl_wr_pulse;
  logic [127:0] stat_in;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] d;
  logic [1:0]  r;

  always #5 clk = ~clk;

  s_axil_regfile #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (4),
    .N_CTRL      (4),
    .N_STAT      (4),
    .CTRL_RESET  (128'h1),
    .STICKY_MASK (128'hFF),
    .SYNC_STAGES (2)
  ) dut (
    .axi_clock      (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (3'b000),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (3'b000),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .ctrl_regs      (ctrl_regs),
    .ctrl_wr_pulse  (ctrl_wr_pulse),
    .stat_in        (stat_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] creg(input int k);
    return ctrl_regs[k*32 +: 32];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp);
    logic hs;
    logic ok;
    araddr  = a;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      hs = arready;
      @(negedge clk);
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("rd_timeout", 32'(ok), 32'd1);
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] resp);
    logic aw_hs, w_hs, ok;
    awaddr = a; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      aw_hs = awready;
      w_hs  = wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("wr_timeout", 32'(ok), 32'd1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; stat_in = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // 1: reset state and first reads
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_reg0",    creg(0),      32'h1);
    chk("rst_pulse",   32'(ctrl_wr_pulse), 32'd0);
    rd(6'h00, d, r); chk("rd00_data", d, 32'h1); chk("rd00_resp", 32'(r), 32'd0);
    rd(6'h04, d, r); chk("rd04_data", d, 32'h0); chk("rd04_resp", 32'(r), 32'd0);

    // 2: AW three cycles ahead of W, partial strobes
    awaddr = 6'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_held_awready", 32'(awready), 32'd0);
    cyc(2);
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("t2_bvalid_early", 32'(bvalid), 32'd0);
    chk("t2_pulse_early",  32'(ctrl_wr_pulse), 32'd0);
    @(negedge clk);
    chk("t2_bvalid",  32'(bvalid), 32'd1);
    chk("t2_bresp",   32'(bresp),  32'd0);
    chk("t2_pulse",   32'(ctrl_wr_pulse), 32'b0100);
    chk("t2_reg2",    creg(2), 32'h00BB00DD);
    @(negedge clk);
    chk("t2_pulse_end", 32'(ctrl_wr_pulse), 32'd0);
    chk("t2_bvalid_hold", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("t2_bvalid_done", 32'(bvalid), 32'd0);

    // 3: B back-pressure blocks a second commit
    awaddr = 6'h0C; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("t3_b1_valid", 32'(bvalid), 32'd1);
    awaddr = 6'h00; wdata = 32'h22222222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("t3_awready_held", 32'(awready), 32'd0);
    chk("t3_wready_held",  32'(wready),  32'd0);
    cyc(3);
    chk("t3_bvalid_stuck", 32'(bvalid), 32'd1);
    chk("t3_reg0_unwritten", creg(0), 32'h1);
    chk("t3_reg3", creg(3), 32'h11111111);
    bready = 1'b1;
    @(negedge clk);
    chk("t3_reg0_commit", creg(0), 32'h22222222);
    chk("t3_b2_valid", 32'(bvalid), 32'd1);
    @(negedge clk);
    bready = 1'b0;
    chk("t3_b2_done", 32'(bvalid), 32'd0);

    // 4: sticky status bit, W1C, set-vs-clear tie, non-sticky passthrough
    stat_in[3] = 1'b1;
    @(negedge clk);
    stat_in[3] = 1'b0;
    cyc(4);
    rd(6'h10, d, r); chk("t4_sticky_set", d, 32'h08); chk("t4_sticky_resp", 32'(r), 32'd0);
    wr(6'h10, 32'h08, 4'h1, r); chk("t4_w1c_resp", 32'(r), 32'd0);
    rd(6'h10, d, r); chk("t4_sticky_clr", d, 32'h0);
    stat_in[3] = 1'b1;
    @(negedge clk);
    stat_in[3] = 1'b0;
    awaddr = 6'h10; wdata = 32'h08; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("t4_tie_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rd(6'h10, d, r); chk("t4_set_wins", d, 32'h08);
    stat_in = {32'h0, 32'h0, 32'h12345678, 32'h00000A00};
    cyc(4);
    rd(6'h14, d, r); chk("t4_stat1", d, 32'h12345678);
    rd(6'h10, d, r); chk("t4_stat0_mix", d, 32'h00000A08);
    stat_in = '0;
    cyc(4);
    rd(6'h10, d, r); chk("t4_stat0_sticky_only", d, 32'h08);

    // Read/write collision on control reg1: read sees the old value
    awaddr = 6'h04; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 6'h04; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("col_rvalid", 32'(rvalid), 32'd1);
    chk("col_rdata_old", rdata, 32'h0);
    chk("col_reg1_new", creg(1), 32'hCAFEF00D);
    rready = 1; bready = 1;
    @(negedge clk);
    rready = 0; bready = 0;
    rd(6'h04, d, r); chk("col_rd_new", d, 32'hCAFEF00D);
    rd(6'h0B, d, r); chk("lowbits_ignored", d, 32'h00BB00DD);

    // 5: out-of-range accesses
    rd(6'h3C, d, r); chk("oor_rdata", d, 32'h0); chk("oor_rresp", 32'(r), 32'd2);
    rd(6'h20, d, r); chk("oor8_rresp", 32'(r), 32'd2);
    rd(6'h1C, d, r); chk("last_stat_resp", 32'(r), 32'd0);
    wr(6'h3C, 32'hFFFFFFFF, 4'hF, r); chk("oor_bresp", 32'(r), 32'd2);
    chk("oor_reg0", creg(0), 32'h22222222);
    chk("oor_reg1", creg(1), 32'hCAFEF00D);
    chk("oor_reg2", creg(2), 32'h00BB00DD);
    chk("oor_reg3", creg(3), 32'h11111111);

    // 6: asynchronous reset while a read response is pending
    araddr = 6'h08; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("t6_rvalid_pending", 32'(rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rvalid_async", 32'(rvalid), 32'd0);
    chk("t6_arready", 32'(arready), 32'd1);
    chk("t6_reg2", creg(2), 32'h0);
    chk("t6_reg0", creg(0), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(6'h08, d, r); chk("t6_rd_reg2", d, 32'h0);
    rd(6'h10, d, r); chk("t6_sticky_cleared", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
